sinkx1_inf: RTL

- Receive-side counterpart of the datapath source interface. Consumes the 32-bit IQ stream, frame head and antenna-slot marker.
- Locks to the frame timing and de-interleaves the 4 antenna TDM slots.
- Checks window gating and the ramp test pattern, and reports lock status and saturating error counters.
- Sits at the far end of the source link; used in loopback and board bring-up.

---
 rtl/sinkx1_inf.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sinkx1_inf.sv
// Receive-side sink for the datapath source link: frame lock, antenna slot
// de-interleave, window/ramp checking and saturating status counters.
module sinkx1_inf #(
    parameter int FRAME_LEN   = 4915200,
    parameter int CNT_W       = 24,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             asy_rst,
    input  logic             i_fram_hd,
    input  logic [31:0]      i_data_iq,
    input  logic             i_ant8_sel,
    input  logic [CNT_W-1:0] i_data_start,
    input  logic [CNT_W-1:0] i_data_end,
    input  logic [1:0]       i_chk_mode,
    input  logic             i_clr,
    output logic [31:0]      o_ant_data,
    output logic [1:0]       o_ant_idx,
    output logic             o_ant_vld,
    output logic             o_fram_hd,
    output logic             o_lock,
    output logic [ERR_W-1:0] o_hd_err_cnt,
    output logic [ERR_W-1:0] o_slot_err_cnt,
    output logic [ERR_W-1:0] o_data_err_cnt,
    output logic [ERR_W-1:0] o_frame_cnt
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(FRAME_LEN - 1);
    localparam int               GOOD_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_FRAMES);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [GOOD_W-1:0] w_good_inc;
    logic [1:0]        r_slot_cnt;
    logic [1:0]        w_slot;
    logic [15:0]       r_ramp_ref;
    logic              r_ramp_seeded;
    logic [31:0]       r_ant_data;
    logic [1:0]        r_ant_idx;
    logic              r_ant_vld;
    logic              r_fram_hd;
    logic [ERR_W-1:0]  r_hd_err_cnt;
    logic [ERR_W-1:0]  r_slot_err_cnt;
    logic [ERR_W-1:0]  r_data_err_cnt;
    logic [ERR_W-1:0]  r_frame_cnt;

    logic w_locked;
    logic w_at_last;
    logic w_in_win;
    logic w_ramp_chk;
    logic w_ramp_err;
    logic w_zero_err;
    logic w_inc_frame;
    logic w_inc_hd;
    logic w_inc_slot;
    logic w_inc_data;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v, input logic inc);
        if (inc && (v != {ERR_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

    assign w_locked   = (r_state == ST_LOCK);
    assign w_at_last  = (r_cycle_cnt == LAST_CYC);
    assign w_in_win   = (i_data_start <= r_cycle_cnt) && (r_cycle_cnt <= i_data_end);
    assign w_good_inc = r_good_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_inc_frame = 1'b0;
        w_inc_hd    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (i_fram_hd) begin
                    w_state_nxt = ST_ALIGN;
                    w_good_nxt  = '0;
                end
            end
            ST_ALIGN: begin
                if (i_fram_hd && w_at_last) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc == GOOD_TGT)
                        w_state_nxt = ST_LOCK;
                end else if (i_fram_hd || w_at_last) begin
                    w_good_nxt = '0;
                end
            end
            ST_LOCK: begin
                if (i_fram_hd && w_at_last) begin
                    w_inc_frame = 1'b1;
                end else if (i_fram_hd) begin
                    w_inc_hd    = 1'b1;
                    w_state_nxt = ST_ALIGN;
                    w_good_nxt  = '0;
                end else if (w_at_last) begin
                    w_inc_hd    = 1'b1;
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Marker forces slot 0 this cycle; the counter then free-runs from 1.
    assign w_slot     = i_ant8_sel ? 2'd0 : r_slot_cnt;
    assign w_inc_slot = w_locked && i_ant8_sel && (r_slot_cnt != 2'd0);

    assign w_ramp_chk = w_locked && w_in_win;
    assign w_ramp_err = i_chk_mode[0] && w_ramp_chk && r_ramp_seeded &&
                        ((i_data_iq[31:16] != i_data_iq[15:0]) ||
                         (i_data_iq[15:0] != r_ramp_ref + 16'd1));
    assign w_zero_err = i_chk_mode[1] && w_locked && !w_in_win && (i_data_iq != 32'd0);
    assign w_inc_data = w_ramp_err || w_zero_err;

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            r_state     <= ST_SEARCH;
            r_good_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_slot_cnt  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_cycle_cnt <= (i_fram_hd || w_at_last) ? '0 : r_cycle_cnt + 1'b1;
            r_slot_cnt  <= w_slot + 2'd1;
        end
    end

    // The seed flag drops at every frame boundary so the first in-window sample only primes the reference.
    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            r_ramp_ref    <= 16'd0;
            r_ramp_seeded <= 1'b0;
        end else begin
            if (w_ramp_chk)
                r_ramp_ref <= i_data_iq[15:0];
            if (i_fram_hd || w_at_last)
                r_ramp_seeded <= 1'b0;
            else if (w_ramp_chk)
                r_ramp_seeded <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            r_ant_data <= 32'd0;
            r_ant_idx  <= 2'd0;
            r_ant_vld  <= 1'b0;
            r_fram_hd  <= 1'b0;
        end else begin
            r_ant_data <= i_data_iq;
            r_ant_idx  <= w_slot;
            r_ant_vld  <= w_locked && w_in_win;
            r_fram_hd  <= i_fram_hd && (w_state_nxt == ST_LOCK);
        end
    end

    always_ff @(posedge clk or posedge asy_rst) begin
        if (asy_rst) begin
            r_hd_err_cnt   <= '0;
            r_slot_err_cnt <= '0;
            r_data_err_cnt <= '0;
            r_frame_cnt    <= '0;
        end else if (i_clr) begin
            r_hd_err_cnt   <= '0;
            r_slot_err_cnt <= '0;
            r_data_err_cnt <= '0;
            r_frame_cnt    <= '0;
        end else begin
            r_hd_err_cnt   <= sat_inc(r_hd_err_cnt, w_inc_hd);
            r_slot_err_cnt <= sat_inc(r_slot_err_cnt, w_inc_slot);
            r_data_err_cnt <= sat_inc(r_data_err_cnt, w_inc_data);
            r_frame_cnt    <= sat_inc(r_frame_cnt, w_inc_frame);
        end
    end

    assign o_ant_data     = r_ant_data;
    assign o_ant_idx      = r_ant_idx;
    assign o_ant_vld      = r_ant_vld;
    assign o_fram_hd      = r_fram_hd;
    assign o_lock         = w_locked;
    assign o_hd_err_cnt   = r_hd_err_cnt;
    assign o_slot_err_cnt = r_slot_err_cnt;
    assign o_data_err_cnt = r_data_err_cnt;
    assign o_frame_cnt    = r_frame_cnt;

endmodule
